// File: rtl/tis_node_seq.sv
// Instruction sequencer for one TIS-100 compute node: fetch/decode, ACC/BAK
// register-block strobes, jump resolution and blocking port handshakes.
module tis_node_seq #(
    parameter int unsigned PROG_LEN = 16,
    localparam int unsigned PC_W = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic [10:0]     acc_in,
    output logic [10:0]     new_acc,
    output logic            wen,
    output logic            sav,
    output logic            swp,
    input  logic [10:0]     in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [10:0]     out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int unsigned DW = 11;
    localparam int unsigned JW = ((PC_W > DW) ? PC_W : DW) + 2;

    localparam logic [0:0] S_RUN      = 1'b0;
    localparam logic [0:0] S_OUT_WAIT = 1'b1;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_NEG = 4'h3;
    localparam logic [3:0] OP_SAV = 4'h4;
    localparam logic [3:0] OP_SWP = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JEZ = 4'h9;
    localparam logic [3:0] OP_JNZ = 4'hA;
    localparam logic [3:0] OP_JGZ = 4'hB;
    localparam logic [3:0] OP_JLZ = 4'hC;
    localparam logic [3:0] OP_JRO = 4'hD;

    localparam logic signed [DW:0]   SAT_MAX = (DW+1)'(999);
    localparam logic signed [DW:0]   SAT_MIN = -SAT_MAX;
    localparam logic [PC_W-1:0]      PC_LAST = PC_W'(PROG_LEN - 1);
    localparam logic signed [JW-1:0] JRO_MAX = JW'(PROG_LEN - 1);

    // Clamp a 12-bit signed intermediate into the legal node range.
    function automatic logic [DW-1:0] sat(input logic signed [DW:0] v);
        if (v > SAT_MAX) return DW'(SAT_MAX);
        if (v < SAT_MIN) return DW'(SAT_MIN);
        return v[DW-1:0];
    endfunction

    logic [PC_W-1:0] r_pc;
    logic [0:0]      r_state;
    logic [DW-1:0]   r_out_data;
    logic            r_out_valid;

    logic [PC_W-1:0] w_pc_nxt;
    logic [0:0]      w_state_nxt;
    logic [DW-1:0]   w_out_data_nxt;
    logic            w_out_valid_nxt;

    logic [3:0]             w_op;
    logic                   w_src;
    logic [DW-1:0]          w_imm;
    logic [DW-1:0]          w_s;
    logic signed [DW:0]     w_acc_x;
    logic signed [DW:0]     w_s_x;
    logic signed [DW:0]     w_add;
    logic signed [DW:0]     w_sub;
    logic signed [DW:0]     w_neg;
    logic [DW-1:0]          w_alu;
    logic                   w_fire;
    logic                   w_cond;
    logic [PC_W-1:0]        w_pc_inc;
    logic [PC_W-1:0]        w_jmp_raw;
    logic [PC_W-1:0]        w_jmp_tgt;
    logic signed [JW-1:0]   w_jro_sum;
    logic [PC_W-1:0]        w_jro_tgt;

    assign w_op  = imem_data[15:12];
    assign w_src = imem_data[11];
    assign w_imm = imem_data[10:0];
    assign w_s   = w_src ? in_data : w_imm;

    assign w_acc_x = {acc_in[DW-1], acc_in};
    assign w_s_x   = {w_s[DW-1], w_s};
    assign w_add   = w_acc_x + w_s_x;
    assign w_sub   = w_acc_x - w_s_x;
    assign w_neg   = -w_acc_x;

    always_comb begin
        case (w_op)
            OP_ADD:  w_alu = sat(w_add);
            OP_SUB:  w_alu = sat(w_sub);
            OP_NEG:  w_alu = sat(w_neg);
            default: w_alu = sat(w_s_x);
        endcase
    end

    // Jump conditions look at the live ACC from the register block.
    always_comb begin
        case (w_op)
            OP_JMP:  w_cond = 1'b1;
            OP_JEZ:  w_cond = (acc_in == '0);
            OP_JNZ:  w_cond = (acc_in != '0);
            OP_JGZ:  w_cond = ~acc_in[DW-1] & (acc_in != '0);
            OP_JLZ:  w_cond = acc_in[DW-1];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_pc_inc  = (r_pc == PC_LAST) ? '0 : r_pc + PC_W'(1);
    assign w_jmp_raw = w_imm[PC_W-1:0];
    assign w_jmp_tgt = ({1'b0, w_jmp_raw} >= (PC_W+1)'(PROG_LEN))
                       ? w_jmp_raw - PC_W'(PROG_LEN) : w_jmp_raw;

    // Relative jump saturates at both ends of the program instead of wrapping.
    assign w_jro_sum = $signed({{(JW-PC_W){1'b0}}, r_pc})
                     + $signed({{(JW-DW){w_s[DW-1]}}, w_s});
    assign w_jro_tgt = w_jro_sum[JW-1]      ? '0 :
                       (w_jro_sum > JRO_MAX) ? PC_LAST :
                                               w_jro_sum[PC_W-1:0];

    assign w_fire = en & (~w_src | in_valid);

    always_comb begin
        w_pc_nxt        = r_pc;
        w_state_nxt     = r_state;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        wen             = 1'b0;
        sav             = 1'b0;
        swp             = 1'b0;
        in_ready        = 1'b0;
        new_acc         = w_alu;
        case (r_state)
            S_RUN: begin
                in_ready = en & w_src;
                if (w_fire) begin
                    w_pc_nxt = w_pc_inc;
                    case (w_op)
                        OP_ADD, OP_SUB, OP_NEG, OP_MOV: wen = 1'b1;
                        OP_SAV: sav = 1'b1;
                        OP_SWP: swp = 1'b1;
                        OP_OUT: begin
                            w_pc_nxt        = r_pc;
                            w_out_data_nxt  = sat(w_s_x);
                            w_out_valid_nxt = 1'b1;
                            w_state_nxt     = S_OUT_WAIT;
                        end
                        OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ: begin
                            if (w_cond) w_pc_nxt = w_jmp_tgt;
                        end
                        OP_JRO: w_pc_nxt = w_jro_tgt;
                        default: ;
                    endcase
                end
            end
            S_OUT_WAIT: begin
                // out_valid is not gated by en, so the handshake may complete
                // while frozen; the PC step waits for en.
                if (out_ready) w_out_valid_nxt = 1'b0;
                if (en & (out_ready | ~r_out_valid)) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
        if (RST) begin
            wen      = 1'b0;
            sav      = 1'b0;
            swp      = 1'b0;
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc        <= '0;
            r_state     <= S_RUN;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_state     <= w_state_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign imem_addr = r_pc;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
